// File: rtl/vc_router.sv
// vc_router: pulls 6-bit words from a main FIFO and routes each one to VC0 or
// VC1 based on bit 4 of the word, honouring per-VC almost-full back-pressure.
// Optional routed-word counters are built only when VC_ROUTER_CNT_EN is defined;
// otherwise vc0_cnt/vc1_cnt are tied to zero and init is ignored.
module vc_router (
   input  logic       clk,
   input  logic       RESET_L,
   input  logic       main_empty,
   input  logic [5:0] main_data,
   output logic       main_pop,
   input  logic       vc0_almost_full,
   input  logic       vc1_almost_full,
   output logic       vc0_push,
   output logic       vc1_push,
   output logic [5:0] vc_data,
   input  logic       init,
   output logic       active,
   output logic [7:0] vc0_cnt,
   output logic [7:0] vc1_cnt
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_ROUTE = 2'd2;
   localparam logic [1:0] ST_STALL = 2'd3;

   logic [1:0] state_r;
   logic [1:0] state_nxt_s;
   logic [5:0] hold_r;
   logic       active_r;
   logic       route_vc1_s;
   logic       sel_af_s;
   logic       load_s;
   logic       pop_s;
   logic       push0_s;
   logic       push1_s;

   // Destination select: bit 4 of the word picks VC1 when set.
   function automatic logic route_to_vc1(input logic [5:0] word);
      return word[4];
   endfunction

   // Next-state, strobe and hold-load decode from state, held word and inputs.
   always_comb begin
      state_nxt_s = state_r;
      pop_s       = 1'b0;
      push0_s     = 1'b0;
      push1_s     = 1'b0;
      load_s      = 1'b0;
      route_vc1_s = route_to_vc1(hold_r);
      sel_af_s    = route_vc1_s ? vc1_almost_full : vc0_almost_full;
      case (state_r)
         ST_IDLE: begin
            if (!main_empty) begin
               pop_s       = 1'b1;
               state_nxt_s = ST_FETCH;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_FETCH: begin
            // Read data is valid this cycle, one cycle after the pop.
            load_s      = 1'b1;
            state_nxt_s = ST_ROUTE;
         end
         ST_ROUTE, ST_STALL: begin
            if (!sel_af_s) begin
               push0_s = !route_vc1_s;
               push1_s = route_vc1_s;
               // Overlap the next fetch with this push to sustain 1 word / 2 cycles.
               if (!main_empty) begin
                  pop_s       = 1'b1;
                  state_nxt_s = ST_FETCH;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end else begin
               state_nxt_s = ST_STALL;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Strobes are gated by reset so they read 0 while RESET_L is low,
   // even though the IDLE decode would otherwise pop on a non-empty FIFO.
   assign main_pop = RESET_L & pop_s;
   assign vc0_push = RESET_L & push0_s;
   assign vc1_push = RESET_L & push1_s;
   assign vc_data  = hold_r;
   assign active   = active_r;

   // FSM state and registered activity flag.
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         state_r  <= ST_IDLE;
         active_r <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         active_r <= (state_nxt_s != ST_IDLE);
      end
   end

   // Hold register captures the fetched word; it doubles as the vc_data output.
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         hold_r <= 6'd0;
      end else if (load_s) begin
         hold_r <= main_data;
      end else begin
         hold_r <= hold_r;
      end
   end

`ifdef VC_ROUTER_CNT_EN
   logic [7:0] cnt0_r;
   logic [7:0] cnt1_r;

   // Routed-word counters; init clears both and wins over a same-cycle push.
   always_ff @(posedge clk or negedge RESET_L) begin
      if (!RESET_L) begin
         cnt0_r <= 8'd0;
         cnt1_r <= 8'd0;
      end else if (init) begin
         cnt0_r <= 8'd0;
         cnt1_r <= 8'd0;
      end else begin
         cnt0_r <= push0_s ? (cnt0_r + 8'd1) : cnt0_r;
         cnt1_r <= push1_s ? (cnt1_r + 8'd1) : cnt1_r;
      end
   end

   assign vc0_cnt = cnt0_r;
   assign vc1_cnt = cnt1_r;
`else
   logic init_unused_s;

   assign init_unused_s = init;
   assign vc0_cnt       = 8'd0;
   assign vc1_cnt       = 8'd0;
`endif

endmodule
